// File: rtl/fir_out_stage.sv
// Output stage for the FIR core: rounds/saturates the accumulator to OUT_W bits,
// buffers samples in a FIFO and presents them on valid/ready. Optional macro: FIR_OUT_STATS_EN.
module fir_out_stage #(
    parameter int ACC_W      = 38,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 22,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [ACC_W-1:0]         acc_in,
    input  logic                     acc_valid,
    input  logic                     clear,
    output logic [OUT_W-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     sat_flag,
    output logic                     overflow,
    output logic [15:0]              sat_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic signed [ACC_W:0] HALF  = {{ACC_W{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_W:0] Q_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] Q_MIN = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};
    localparam logic [LW-1:0]         FULL_LVL = LW'(DEPTH);

    // ---------------- stage 1: round half-up, then clamp ----------------
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] q;
    logic                  sat_hi;
    logic                  sat_lo;
    logic [OUT_W-1:0]      rounded;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        sum     = $signed({acc_in[ACC_W-1], acc_in}) + HALF;
        q       = sum >>> FRAC_SHIFT;
        sat_hi  = (q > Q_MAX);
        sat_lo  = (q < Q_MIN);
        rounded = q[OUT_W-1:0];
        if (sat_hi)
            rounded = Q_MAX[OUT_W-1:0];
        else if (sat_lo)
            rounded = Q_MIN[OUT_W-1:0];
    end

    logic             s1_valid;
    logic             s1_sat;
    logic [OUT_W-1:0] s1_data;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_sat   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= acc_valid;
            s1_sat   <= acc_valid & (sat_hi | sat_lo);
            if (acc_valid)
                s1_data <= rounded;
        end
    end

    // ---------------- stage 2: FIFO ----------------
    logic [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    head_idx;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign dout_valid = (level != '0);
    assign full       = (level == FULL_LVL);
    assign pop        = dout_valid & dout_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push       = s1_valid & (~full | pop);
    assign drop       = s1_valid & full & ~pop;
    assign head_idx   = pop ? rd_ptr + AW'(1) : rd_ptr;

    // NOTE: the storage array has no reset; only pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s1_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            // dout tracks the next head; bypass when that slot is written this cycle.
            if (push || pop) begin
                if (push && (wr_ptr == head_idx))
                    dout <= s1_data;
                else
                    dout <= mem[head_idx];
            end
        end
    end

    // ---------------- sticky flags: set beats clear ----------------
    logic sat_evt;
    assign sat_evt = s1_valid & s1_sat;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sat_flag <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (sat_evt)
                sat_flag <= 1'b1;
            else if (clear)
                sat_flag <= 1'b0;
            if (drop)
                overflow <= 1'b1;
            else if (clear)
                overflow <= 1'b0;
        end
    end

`ifdef FIR_OUT_STATS_EN
    logic [15:0] sat_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            sat_cnt_q <= '0;
        else if (clear)
            sat_cnt_q <= sat_evt ? 16'd1 : 16'd0;
        else if (sat_evt && (sat_cnt_q != 16'hFFFF))
            sat_cnt_q <= sat_cnt_q + 16'd1;
    end

    assign sat_count = sat_cnt_q;
`else
    assign sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fir_out_stage.sv
// Scoreboard bench for fir_out_stage: stimulus queues expected samples, a negedge monitor pops and compares.
module tb_fir_out_stage;

    localparam int ACC_W = 38;
    localparam int OUT_W = 16;
    localparam int FRAC  = 22;
    localparam int DEPTH = 4;

`ifdef FIR_OUT_STATS_EN
    localparam logic [15:0] SAT_ONE = 16'd1;
`else
    localparam logic [15:0] SAT_ONE = 16'd0;
`endif

    logic               clk;
    logic               resetn;
    logic [ACC_W-1:0]   acc_in;
    logic               acc_valid;
    logic               clear;
    logic [OUT_W-1:0]   dout;
    logic               dout_valid;
    logic               dout_ready;
    logic [2:0]         level;
    logic               sat_flag;
    logic               overflow;
    logic [15:0]        sat_count;

    fir_out_stage #(
        .ACC_W(ACC_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC), .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .acc_in     (acc_in),
        .acc_valid  (acc_valid),
        .clear      (clear),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level),
        .sat_flag   (sat_flag),
        .overflow   (overflow),
        .sat_count  (sat_count)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [OUT_W-1:0] exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: whenever the DUT hands over a sample, compare it against the queue head.
    always @(negedge clk) begin
        if (resetn && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL dout_unexpected: got %0h required no sample", dout);
            end else begin
                check("dout", dout, exp_q.pop_front());
            end
        end
    end

    function automatic logic [ACC_W-1:0] mk(input int k);
        logic [ACC_W-1:0] v;
        v = ACC_W'(k);
        return v << FRAC;
    endfunction

    // Drive one acc_valid pulse; called at posedge+1, returns at the next posedge+1.
    task automatic send(input logic [ACC_W-1:0] acc, input logic [OUT_W-1:0] exp, input bit keep);
        acc_in    = acc;
        acc_valid = 1'b1;
        if (keep)
            exp_q.push_back(exp);
        @(posedge clk);
        #1;
        acc_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_pending", exp_q.size(), 0);
        check("drain_level", level, 0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        resetn     = 1'b0;
        acc_in     = '0;
        acc_valid  = 1'b0;
        clear      = 1'b0;
        dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout_valid", dout_valid, 0);
        check("rst_level", level, 0);
        check("rst_dout", dout, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_overflow", overflow, 0);
        check("rst_sat_count", sat_count, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // 1.0 in Q.22 -> 1, with two-cycle latency
        dout_ready = 1'b1;
        send(38'h0000400000, 16'h0001, 1);
        check("lat_first_edge", dout_valid, 0);
        @(posedge clk);
        #1;
        check("lat_second_edge", dout_valid, 1);
        check("lat_dout", dout, 16'h0001);
        check("one_sat_flag", sat_flag, 0);
        drain();

        // Rounding: half-up toward +inf
        send(38'h0000200000, 16'h0001, 1);
        send(38'h3FFFE00000, 16'h0000, 1);
        send(38'h3FFFDFFFFF, 16'hFFFF, 1);
        drain();
        check("round_sat_flag", sat_flag, 0);

        // Positive saturation, then most-negative value which is exactly representable
        send(38'h1FFFFFFFFF, 16'h7FFF, 1);
        drain();
        check("sat_flag_set", sat_flag, 1);
        check("sat_count_one", sat_count, SAT_ONE);
        pulse_clear();
        check("sat_flag_cleared", sat_flag, 0);
        check("sat_count_cleared", sat_count, 0);
        send(38'h2000000000, 16'h8000, 1);
        drain();
        check("neg_full_no_sat", sat_flag, 0);

        // Back-pressure: five pushes into four entries, fifth dropped
        dout_ready = 1'b0;
        for (int k = 1; k <= 5; k++)
            send(mk(k), OUT_W'(k), k <= 4);
        @(posedge clk);
        #1;
        check("bp_level_full", level, 4);
        check("bp_overflow", overflow, 1);
        check("bp_head", dout, 16'h0001);
        dout_ready = 1'b1;
        drain();
        pulse_clear();
        check("bp_overflow_cleared", overflow, 0);

        // Full FIFO with push and pop on the same edge
        dout_ready = 1'b0;
        for (int k = 10; k <= 13; k++)
            send(mk(k), OUT_W'(k), 1);
        send(mk(14), 16'd14, 1);
        check("fp_level_before", level, 4);
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        check("fp_level_after", level, 4);
        check("fp_overflow", overflow, 0);
        drain();
        check("fp_overflow_end", overflow, 0);

        // Asynchronous reset with three samples buffered
        dout_ready = 1'b0;
        send(mk(20), 16'd20, 0);
        send(38'h1FFFFFFFFF, 16'h7FFF, 0);
        send(mk(22), 16'd22, 0);
        @(posedge clk);
        #1;
        check("mr_level_pre", level, 3);
        check("mr_sat_pre", sat_flag, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("mr_dout_valid", dout_valid, 0);
        check("mr_level", level, 0);
        check("mr_sat_flag", sat_flag, 0);
        check("mr_overflow", overflow, 0);
        check("mr_sat_count", sat_count, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        resetn     = 1'b1;
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        send(mk(30), 16'd30, 1);
        check("mr_lat_first_edge", dout_valid, 0);
        @(posedge clk);
        #1;
        check("mr_lat_second_edge", dout_valid, 1);
        check("mr_lat_dout", dout, 16'd30);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_out_stage.md
Name: fir_out_stage

Overview:
Downstream consumer of the FIR filter core's 38-bit distributed-arithmetic accumulator output.
- Rounds and saturates each accumulator word to a 16-bit signed sample.
- Buffers the samples in a small FIFO.
- Presents them on a valid/ready interface to the next block (DAC formatter or bus bridge).
- Runs on the filter's slow sample clock.
- Isolates the filter from downstream back-pressure and reports saturation and overflow events.

Parameters:
ACC_W, 38, accumulator input width (two's complement)
OUT_W, 16, output sample width (two's complement)
FRAC_SHIFT, 22, number of accumulator LSBs discarded by rounding (must satisfy 1 <= FRAC_SHIFT < ACC_W)
DEPTH, 4, FIFO entries (power of two, >= 2)

Ports:
clk  in  1  sample clock; all state updates on posedge
resetn  in  1  asynchronous active-low reset
acc_in  in  ACC_W  accumulator word from FIR core
acc_valid  in  1  acc_in qualifier, one-cycle pulse per sample
clear  in  1  synchronous clear of sticky flags and stats counter
dout  out  OUT_W  FIFO head sample
dout_valid  out  1  FIFO non-empty
dout_ready  in  1  consumer accepts head when dout_valid & dout_ready
level  out  $clog2(DEPTH)+1  current FIFO occupancy
sat_flag  out  1  sticky: any sample saturated since reset/clear
overflow  out  1  sticky: any sample dropped because FIFO full
sat_count  out  16  number of saturated samples (see Optional Feature)

Behaviour:
- Reset (resetn low, asynchronous): all of the following go to 0: dout, dout_valid, level, sat_flag, overflow, sat_count, stage-1 valid, FIFO pointers. FIFO contents are don't-care.
- Reset asserted mid-operation: any in-flight stage-1 sample and all buffered samples are discarded.
- Stage 1 (registered, cycle N+1 after acc_valid at N):
  - sum = sign_extend(acc_in, ACC_W+1) + 2^(FRAC_SHIFT-1). Rounding is round-half-up, toward +inf.
  - q = sum >>> FRAC_SHIFT (arithmetic shift).
  - If q > 2^(OUT_W-1)-1, result is 2^(OUT_W-1)-1. If q < -2^(OUT_W-1), result is -2^(OUT_W-1). Either case marks the sample saturated.
  - Stage-1 valid = registered acc_valid.
- Stage 2 (push, cycle N+1 edge into FIFO; visible at N+2):
  - Push when stage-1 valid.
  - Empty FIFO: dout/dout_valid reflect the sample at cycle N+2. Total latency acc_valid -> dout_valid is 2 cycles.
- Pop: when dout_valid & dout_ready at an edge, the head advances. dout_ready while empty is ignored.
- dout is always the registered head entry; it is stable while dout_valid & !dout_ready.
- Push and pop in the same cycle:
  - level is unchanged.
  - This holds when full as well: the pop frees the slot, the push is accepted, and no overflow is flagged.
- Push when full without a pop: the sample is dropped, overflow sets, FIFO contents are unchanged.
- Pointers wrap modulo DEPTH. level counts 0..DEPTH.
- sat_flag sets on the cycle a saturated sample leaves stage 1, whether or not that sample is then dropped.
- clear: clears sat_flag, overflow and sat_count at the next edge. If a set event occurs in the same cycle as clear, set wins.
- acc_valid may assert every cycle; sustained throughput is one sample/cycle when dout_ready is held high.

Optional Feature:
Macro: FIR_OUT_STATS_EN
- Defined: sat_count increments by 1 for each saturated sample leaving stage 1. It saturates at 16'hFFFF (no wrap) and is cleared by clear or reset.
- Not defined: the sat_count port remains, tied to 16'h0000, with no counter logic. sat_flag is unaffected in both builds.

Test Plan:
- Reset then acc_in=38'h0000400000 (1.0) with one acc_valid pulse, dout_ready=1 -> dout_valid high exactly 2 cycles later, dout=16'h0001, sat_flag=0.
- Rounding: acc_in=2^21 -> dout=1; acc_in=-(2^21) -> dout=0; acc_in=-(2^21)-1 -> dout=16'hFFFF.
- Saturation: acc_in=2^37-1 -> dout=16'h7FFF, sat_flag=1, sat_count=1 (stats build); acc_in=-2^37 -> dout=16'h8000, no saturation.
- Back-pressure: dout_ready=0, push 5 samples 1..5 (DEPTH=4) -> level=4, overflow=1, then drain -> dout sequence 1,2,3,4.
- Full with simultaneous pop: FIFO full, dout_ready=1 and acc_valid reaching stage 2 in the same cycle -> level stays 4, overflow stays 0, output order preserved.
- Assert resetn low mid-stream with level=3 -> dout_valid, level, flags drop to 0 immediately (asynchronously); first sample after release appears with 2-cycle latency.
